// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory controller port among NREQ requesters.
// One transaction at a time: grant in IDLE, present the command in ISSUE until
// the controller accepts it, then wait in WAIT for the completion pulse.
module mem_port_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned ADDR_BIT = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2*NREQ-1:0]        req_rw_flag,
  input  logic [ADDR_BIT*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0]       req_write_data,
  input  logic [4*NREQ-1:0]        req_write_mask,
  output logic [32*NREQ-1:0]       req_read_data,
  output logic [NREQ-1:0]          req_busy,
  output logic [NREQ-1:0]          req_done,
  output logic [1:0]               mem_rw_flag,
  output logic [ADDR_BIT-1:0]      mem_addr,
  output logic [31:0]              mem_write_data,
  output logic [3:0]               mem_write_mask,
  input  logic [31:0]              mem_read_data,
  input  logic                     mem_busy,
  input  logic                     mem_done
);

  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned FLAG_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   g;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [FLAG_W-1:0]  win_flag;
  logic [ADDR_BIT-1:0] win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic [MASK_W-1:0]  win_mask;
  int unsigned        cand;
  logic [FLAG_W-1:0]  cand_flag;

  // Round-robin scan from ptr: first requester with a read or write flag wins
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_flag  = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_mask  = '0;
    cand      = 0;
    cand_flag = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_flag = req_rw_flag[FLAG_W*cand +: FLAG_W];
      if (!win_valid && (cand_flag == 2'd1 || cand_flag == 2'd2)) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(cand);
        win_flag  = cand_flag;
        win_addr  = req_addr[ADDR_BIT*cand +: ADDR_BIT];
        win_wdata = req_write_data[DATA_W*cand +: DATA_W];
        win_mask  = req_write_mask[MASK_W*cand +: MASK_W];
      end
    end
  end

  // Arbiter FSM with registered port and requester outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= S_IDLE;
      ptr            <= '0;
      g              <= '0;
      mem_rw_flag    <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write_mask <= '0;
      req_read_data  <= '0;
      req_done       <= '0;
      req_busy       <= '1;
    end else begin
      req_done <= '0;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            g              <= win_idx;
            mem_rw_flag    <= win_flag;
            mem_addr       <= win_addr;
            mem_write_data <= win_wdata;
            mem_write_mask <= win_mask;
            req_busy       <= ~(NREQ'(1) << win_idx);
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Command is held until the controller is free to take it
          if (!mem_busy) begin
            mem_rw_flag <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            req_read_data[DATA_W*g +: DATA_W] <= mem_read_data;
            req_done <= NREQ'(1) << g;
            ptr      <= (g == IDX_W'(NREQ - 1)) ? '0 : g + IDX_W'(1);
            req_busy <= '1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one memory_controller port among NREQ requesters (e.g. instruction fetch, data access, debug loader). It sits between the requesters inside cpu_core and a single port of memory_controller. It latches one request at a time, presents it to the controller when the port is free, and returns the registered read data and a one-cycle done pulse to the winning requester. Fairness is guaranteed: every persistent requester is served within NREQ transactions.

## Interface
- NREQ, 2: number of requesters, 2..4
- ADDR_BIT, 32: address width
- CLK  input  1  clock, all state on rising edge
- RST  input  1  reset, asynchronous, active-low
- req_rw_flag  input  2*NREQ  per requester: 0 idle, 1 read, 2 write, 3 reserved (ignored)
- req_addr  input  ADDR_BIT*NREQ  per-requester address
- req_write_data  input  32*NREQ  per-requester write data
- req_write_mask  input  4*NREQ  per-requester byte enables
- req_read_data  output  32*NREQ  read data, valid in the cycle req_done[i] is high
- req_busy  output  NREQ  1 = requester i not currently being served
- req_done  output  NREQ  one-cycle completion pulse
- mem_rw_flag  output  2  to controller port
- mem_addr  output  ADDR_BIT
- mem_write_data  output  32
- mem_write_mask  output  4
- mem_read_data  input  32
- mem_busy  input  1  controller cannot accept a new command
- mem_done  input  1  one-cycle completion pulse from controller

## Operation
- Requester protocol: hold req_rw_flag (and addr/data/mask) stable and nonzero until req_done[i] pulses; drop to 0 or issue the next request in the cycle after done.
- Request fields are latched at grant; later changes are ignored until that transaction completes.
- States: IDLE, ISSUE, WAIT.
- IDLE: scan requesters starting at pointer ptr, wrapping modulo NREQ; the first with flag 1 or 2 wins. Latch index g, flag, addr, data, mask; go to ISSUE. With no valid request, stay in IDLE.
- ISSUE: drive mem_rw_flag = latched flag with the latched fields. If mem_busy = 0 this cycle, the command is accepted; go to WAIT. Otherwise hold the command and stay in ISSUE.
- WAIT: mem_rw_flag = 0. On mem_done, register mem_read_data into req_read_data[g], pulse req_done[g] next cycle, set ptr = (g+1) mod NREQ, go to IDLE.
- req_busy[i] = 0 only for i = g while in ISSUE or WAIT; otherwise 1.
- Flag value 3 is never granted.
- A request withdrawn mid-transaction still completes, and its done pulse is still produced.
- mem_done in IDLE or ISSUE is ignored (spurious).
- mem_addr, mem_write_data and mem_write_mask hold their last latched values when idle. Write data for a read is don't-care.

## Timing
- Reset (RST = 0, async) sets:
  - state IDLE, ptr 0
  - mem_rw_flag 0, mem_addr / mem_write_data / mem_write_mask 0
  - req_read_data 0, req_done 0, req_busy all 1
- Reset is honoured in any state. An in-flight transaction is abandoned with no done pulse, and a late mem_done after release is ignored as spurious.
- Cycle 0: request visible in IDLE. Cycle 1: mem_rw_flag asserted, at the earliest.
- If mem_done arrives in cycle k, req_done[g] and the data are valid in cycle k+1 and the state is IDLE in cycle k+1.
- Next grant: decided in cycle k+1 with mem_rw_flag in cycle k+2. Minimum turnaround is 2 cycles between consecutive commands.
- mem_rw_flag is never asserted in two consecutive accepted cycles.
- At most one req_done bit is high in any cycle.

## Test plan
- Single read, NREQ=2:
  - Stimulus: req 0 reads 0x100; controller idle, mem_done 3 cycles after acceptance with data 0xDEADBEEF.
  - Required: mem_rw_flag=1 at cycle 1, addr 0x100; req_done[0] at cycle 5 with req_read_data[0] = 0xDEADBEEF.
- Simultaneous requests:
  - Stimulus: req 0 and req 1 both continuously request from reset.
  - Required: service order 0,1,0,1; each done pulse is alternate; neither starves.
- Busy backpressure:
  - Stimulus: req 1 writes 0x55AA to 0x20 with mask 4'b0011; mem_busy held 1 for 4 cycles.
  - Required: command held stable for all 4 cycles, accepted on the first busy=0 cycle, exactly one write reaches the controller.
- Request change during WAIT:
  - Stimulus: req 0's addr is changed from 0x40 to 0x80 while in WAIT.
  - Required: the controller saw only 0x40; done is returned to req 0.
- Reserved flag and spurious done:
  - Stimulus: req 0 flag = 3; mem_done pulsed while IDLE.
  - Required: no grant, no req_done, state stays IDLE.
- Async reset mid-WAIT:
  - Stimulus: RST pulled low between clock edges, then released; controller then pulses mem_done.
  - Required: outputs reset immediately; the late mem_done is ignored; the next request goes to req 0 (ptr = 0).
